// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/data-size encodings and the receive FIFO entry.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam logic DS_8 = 1'b0;
  localparam logic DS_7 = 1'b1;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with head read straight from storage (no read latency).
module sync_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata_o = empty_o ? '0 : mem[rd_ptr_reg];
  assign count_o = count_reg;

endmodule

// File: rtl/rx_backend.sv
// UART receive back end: decodes frames per control register, queues them with
// parity/framing flags and keeps a sticky overrun flag.
module rx_backend
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cr_ds_i,
  input  logic [1:0]               cr_p_i,
  input  logic                     cr_s_i,
  input  logic [10:0]              frame_i,
  input  logic                     frame_valid_i,
  input  logic                     rd_i,
  input  logic                     clr_ovr_i,
  output logic [7:0]               rd_data_o,
  output logic                     rd_pe_o,
  output logic                     rd_fe_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovr_o
);

  rx_entry_t  dec_entry;
  rx_entry_t  head_entry;
  logic       par_en;
  logic       par_bit;
  logic [3:0] stop_idx;
  logic       fifo_full;
  logic       fifo_empty;
  logic       ovr_reg;

  always_comb begin
    dec_entry      = '0;
    par_en         = (cr_p_i == PARITY_EVEN) || (cr_p_i == PARITY_ODD);
    par_bit        = (cr_ds_i == DS_7) ? frame_i[7] : frame_i[8];
    dec_entry.data = (cr_ds_i == DS_7) ? {1'b0, frame_i[6:0]} : frame_i[7:0];
    // First stop bit sits right after the data bits, shifted by one when parity is present.
    stop_idx       = ((cr_ds_i == DS_7) ? 4'd7 : 4'd8) + {3'b000, par_en};
    dec_entry.fe   = !frame_i[stop_idx] || (cr_s_i && !frame_i[stop_idx + 4'd1]);
    if (cr_p_i == PARITY_EVEN)
      dec_entry.pe = ^{dec_entry.data, par_bit};
    else if (cr_p_i == PARITY_ODD)
      dec_entry.pe = !(^{dec_entry.data, par_bit});
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (frame_valid_i),
    .wdata_i (dec_entry),
    .pop_i   (rd_i),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // A frame is lost only when full with no pop freeing a slot; setting beats clearing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   ovr_reg <= 1'b0;
    else if (frame_valid_i && fifo_full && !rd_i)  ovr_reg <= 1'b1;
    else if (clr_ovr_i)                            ovr_reg <= 1'b0;
  end

  assign rd_data_o  = head_entry.data;
  assign rd_pe_o    = head_entry.pe;
  assign rd_fe_o    = head_entry.fe;
  assign rd_valid_o = !fifo_empty;
  assign ovr_o      = ovr_reg;

endmodule

// File: tb/tb_rx_backend.sv
// Self-checking bench for rx_backend: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_rx_backend;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic [10:0] frame_i;
  logic        frame_valid_i;
  logic        rd_i;
  logic        clr_ovr_i;
  logic [7:0]  rd_data_o;
  logic        rd_pe_o;
  logic        rd_fe_o;
  logic        rd_valid_o;
  logic [3:0]  count_o;
  logic        ovr_o;

  int checks = 0;
  int failures = 0;

  logic [9:0] model_q[$];
  logic       model_ovr;

  rx_backend #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cr_ds_i       (cr_ds_i),
    .cr_p_i        (cr_p_i),
    .cr_s_i        (cr_s_i),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .rd_i          (rd_i),
    .clr_ovr_i     (clr_ovr_i),
    .rd_data_o     (rd_data_o),
    .rd_pe_o       (rd_pe_o),
    .rd_fe_o       (rd_fe_o),
    .rd_valid_o    (rd_valid_o),
    .count_o       (count_o),
    .ovr_o         (ovr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode straight from the frame layout rules: data bits, optional parity, stop bits.
  function automatic logic [9:0] model_decode(input logic [10:0] f, input logic ds,
                                              input logic [1:0] p, input logic s);
    int n, idx, ones;
    logic [7:0] d;
    logic pe, fe;
    n = ds ? 7 : 8;
    d = 8'h00;
    for (int i = 0; i < n; i++) d[i] = f[i];
    idx = n;
    pe = 1'b0;
    if (p == 2'b01 || p == 2'b10) begin
      ones = $countones(d) + int'(f[n]);
      pe = (p == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      idx++;
    end
    fe = (f[idx] == 1'b0) || (s && f[idx+1] == 1'b0);
    return {fe, pe, d};
  endfunction

  task automatic compare_all(input string tag);
    logic [9:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 10'h000;
    check({tag, ".valid"}, 32'(rd_valid_o), 32'(model_q.size() > 0));
    check({tag, ".count"}, 32'(count_o),    32'(model_q.size()));
    check({tag, ".ovr"},   32'(ovr_o),      32'(model_ovr));
    check({tag, ".data"},  32'(rd_data_o),  32'(head[7:0]));
    check({tag, ".pe"},    32'(rd_pe_o),    32'(head[8]));
    check({tag, ".fe"},    32'(rd_fe_o),    32'(head[9]));
  endtask

  // One clock: model follows the inputs held across the edge, then strobes drop and outputs are checked.
  task automatic tick(input string tag);
    bit full, popping, pushing;
    logic [9:0] ent;
    @(posedge clk_i);
    if (!rst_ni) begin
      model_q.delete();
      model_ovr = 1'b0;
    end else begin
      full    = (model_q.size() == DEPTH);
      popping = rd_i && (model_q.size() > 0);
      pushing = frame_valid_i && (!full || popping);
      ent     = model_decode(frame_i, cr_ds_i, cr_p_i, cr_s_i);
      if (frame_valid_i && full && !rd_i) model_ovr = 1'b1;
      else if (clr_ovr_i)                 model_ovr = 1'b0;
      if (popping) void'(model_q.pop_front());
      if (pushing) model_q.push_back(ent);
    end
    #1;
    frame_valid_i = 1'b0;
    rd_i          = 1'b0;
    clr_ovr_i     = 1'b0;
    compare_all(tag);
  endtask

  task automatic send(input logic [10:0] f, input logic ds, input logic [1:0] p,
                      input logic s, input logic pop, input string tag);
    cr_ds_i = ds; cr_p_i = p; cr_s_i = s;
    frame_i = f; frame_valid_i = 1'b1; rd_i = pop;
    tick(tag);
  endtask

  task automatic pop_one(input string tag);
    rd_i = 1'b1;
    tick(tag);
  endtask

  initial begin
    rst_ni = 1'b1;
    cr_ds_i = 1'b0; cr_p_i = 2'b00; cr_s_i = 1'b0;
    frame_i = '0; frame_valid_i = 1'b0; rd_i = 1'b0; clr_ovr_i = 1'b0;
    model_ovr = 1'b0;
    #2 rst_ni = 1'b0;
    #1 compare_all("reset");
    tick("reset_hold");
    rst_ni = 1'b1;
    tick("idle");

    // 8N1 basic frame
    send(11'h145, 1'b0, 2'b00, 1'b0, 1'b0, "8n1");
    check("8n1_data", 32'(rd_data_o), 32'h45);
    check("8n1_count", 32'(count_o), 32'd1);
    pop_one("8n1_pop");
    check("8n1_empty", 32'(rd_valid_o), 32'd0);

    // Parity modes
    send(11'h203, 1'b0, 2'b01, 1'b0, 1'b0, "8e1_ok");
    check("8e1_pe0", 32'(rd_pe_o), 32'd0);
    pop_one("8e1_ok_pop");
    send(11'h303, 1'b0, 2'b01, 1'b0, 1'b0, "8e1_bad");
    check("8e1_pe1", 32'(rd_pe_o), 32'd1);
    pop_one("8e1_bad_pop");
    send(11'h203, 1'b0, 2'b10, 1'b0, 1'b0, "8o1");
    check("8o1_pe1", 32'(rd_pe_o), 32'd1);
    pop_one("8o1_pop");

    // 7N2 stop-bit checking
    send(11'h0FF, 1'b1, 2'b00, 1'b1, 1'b0, "7n2_bad");
    check("7n2_data", 32'(rd_data_o), 32'h7F);
    check("7n2_fe1", 32'(rd_fe_o), 32'd1);
    pop_one("7n2_bad_pop");
    send(11'h1FF, 1'b1, 2'b00, 1'b1, 1'b0, "7n2_ok");
    check("7n2_fe0", 32'(rd_fe_o), 32'd0);
    pop_one("7n2_ok_pop");

    // Fill, overrun, clear, push+pop while full, drain
    for (int i = 0; i < DEPTH; i++) send(11'h100 | 11'(i), 1'b0, 2'b00, 1'b0, 1'b0, "fill");
    send(11'h1AA, 1'b0, 2'b00, 1'b0, 1'b0, "overrun");
    check("ovr_count", 32'(count_o), 32'd8);
    check("ovr_set", 32'(ovr_o), 32'd1);
    clr_ovr_i = 1'b1;
    tick("clr_ovr");
    check("ovr_clr", 32'(ovr_o), 32'd0);
    check("full_head", 32'(rd_data_o), 32'h00);
    send(11'h1BB, 1'b0, 2'b00, 1'b0, 1'b1, "full_pushpop");
    check("pp_count", 32'(count_o), 32'd8);
    check("pp_ovr", 32'(ovr_o), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_order", 32'(rd_data_o), 32'(i));
      pop_one("drain");
    end
    check("drain_last", 32'(rd_data_o), 32'hBB);
    pop_one("drain_bb");
    pop_one("pop_empty");
    check("pop_empty_cnt", 32'(count_o), 32'd0);

    // Coincident clear and new overrun: set wins
    for (int i = 0; i < DEPTH; i++) send(11'h155, 1'b0, 2'b00, 1'b0, 1'b0, "fill2");
    clr_ovr_i = 1'b1;
    send(11'h1CC, 1'b0, 2'b00, 1'b0, 1'b0, "set_beats_clr");
    check("set_wins", 32'(ovr_o), 32'd1);

    // Async reset mid-stream with 3 entries
    clr_ovr_i = 1'b1;
    tick("clr2");
    for (int i = 0; i < DEPTH - 3; i++) pop_one("trim");
    check("pre_rst_cnt", 32'(count_o), 32'd3);
    #3 rst_ni = 1'b0;
    model_q.delete();
    model_ovr = 1'b0;
    #1 compare_all("async_rst");
    tick("rst_hold");
    rst_ni = 1'b1;
    send(11'h15A, 1'b0, 2'b00, 1'b0, 1'b0, "post_rst");
    check("post_rst_data", 32'(rd_data_o), 32'h5A);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cr_ds_i       = 1'($urandom);
      cr_p_i        = 2'($urandom);
      cr_s_i        = 1'($urandom);
      frame_i       = 11'($urandom);
      frame_valid_i = ($urandom_range(0, 99) < 55);
      rd_i          = ($urandom_range(0, 99) < 40);
      clr_ovr_i     = ($urandom_range(0, 99) < 10);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
